// File: rtl/mdu.sv
// Multiply/divide unit owning the HI/LO registers: multi-cycle MULT/MULTU/MUL and a
// 32-step restoring divider for DIV/DIVU, with pipeline stall, hold and flush handling.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mdu_op_i,
  input  logic        en_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  typedef enum logic [1:0] {IDLE, MULB, DIVB, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hiTmp_q, hiTmp_d, loTmp_q, loTmp_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        negQuo_q, negQuo_d, negRem_q, negRem_d;

  logic        isDiv, isMul, signedDiv;
  logic [31:0] absA, absB;
  logic        mulSigned;
  logic [63:0] aExt, bExt, product;
  logic [32:0] shifted;
  logic [31:0] diff, stepRem, stepQuo;
  logic        qBit;

  // Operand conditioning and datapath; quo_q/dvsr_q double as multiplier operands.
  always_comb begin
    isDiv     = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
    isMul     = (mdu_op_i == OP_MUL) || (mdu_op_i == OP_MULT) || (mdu_op_i == OP_MULTU);
    signedDiv = (mdu_op_i == OP_DIV);
    absA      = (signedDiv && a_i[31]) ? -a_i : a_i;
    absB      = (signedDiv && b_i[31]) ? -b_i : b_i;
    mulSigned = (op_q != OP_MULTU);
    aExt      = {(mulSigned ? {32{quo_q[31]}} : 32'h0), quo_q};
    bExt      = {(mulSigned ? {32{dvsr_q[31]}} : 32'h0), dvsr_q};
    product   = aExt * bExt;
    shifted   = {rem_q, quo_q[31]};
    qBit      = (shifted >= {1'b0, dvsr_q});
    diff      = shifted[31:0] - dvsr_q;
    stepRem   = qBit ? diff : shifted[31:0];
    stepQuo   = {quo_q[30:0], qBit};
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hiTmp_d  = hiTmp_q;
    loTmp_d  = loTmp_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
    stall_o  = 1'b0;
    result_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          if ((isDiv || isMul) && !flush_i) begin
            stall_o = 1'b1;
            op_d    = mdu_op_i;
            if (isDiv) begin
              quo_d    = absA;
              dvsr_d   = absB;
              rem_d    = 32'h0;
              cnt_d    = 5'd0;
              // A zero divisor leaves the all-ones quotient unsigned.
              negQuo_d = signedDiv && (a_i[31] ^ b_i[31]) && (b_i != 32'h0);
              negRem_d = signedDiv && a_i[31];
              state_d  = DIVB;
            end else begin
              quo_d   = a_i;
              dvsr_d  = b_i;
              state_d = MULB;
            end
          end
          case (mdu_op_i)
            OP_MFHI: result_o = hi_q;
            OP_MFLO: result_o = lo_q;
            OP_MTHI: if (!flush_i && !hold_i) hi_d = a_i;
            OP_MTLO: if (!flush_i && !hold_i) lo_d = a_i;
            default: ;
          endcase
        end
      end
      MULB: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          hiTmp_d = product[63:32];
          loTmp_d = product[31:0];
          state_d = DONE;
        end
      end
      DIVB: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            loTmp_d = negQuo_q ? -stepQuo : stepQuo;
            hiTmp_d = negRem_q ? -stepRem : stepRem;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (op_q == OP_MUL) result_o = loTmp_q;
        if (flush_i) begin
          state_d = IDLE;
        end else if (!hold_i) begin
          if (op_q != OP_MUL) begin
            hi_d = hiTmp_q;
            lo_d = loTmp_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= 32'h0;
      lo_q     <= 32'h0;
      hiTmp_q  <= 32'h0;
      loTmp_q  <= 32'h0;
      op_q     <= 4'd0;
      cnt_q    <= 5'd0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      dvsr_q   <= 32'h0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hiTmp_q  <= hiTmp_d;
      loTmp_q  <= loTmp_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: multiply/divide results, latency, HI/LO moves,
// hold/flush behaviour and asynchronous reset, with hand-computed expectations.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mdu_op_i;
  logic        en_i, hold_i, flush_i;
  logic [31:0] a_i, b_i;
  logic [31:0] result_o, hi_o, lo_o;
  logic        stall_o;

  int vectors = 0;
  int miscompares = 0;
  int stalls;

  mdu dut (
    .clk      (clk),
    .rst      (rst),
    .mdu_op_i (mdu_op_i),
    .en_i     (en_i),
    .hold_i   (hold_i),
    .flush_i  (flush_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .stall_o  (stall_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [3:0] op, input logic en, input logic hold,
                               input logic flush, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdu_op_i = op;
    en_i     = en;
    hold_i   = hold;
    flush_i  = flush;
    a_i      = a;
    b_i      = b;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(OP_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Holds the instruction in EX while stalled; returns in the first non-stalled cycle.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nStall);
    nStall = 0;
    applyStimulus(op, 1'b1, 1'b0, 1'b0, a, b);
    while (stall_o === 1'b1 && nStall < 100) begin
      nStall++;
      applyStimulus(op, 1'b1, 1'b0, 1'b0, a, b);
    end
  endtask

  initial begin
    rst = 1'b1;
    mdu_op_i = OP_NONE; en_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    a_i = 32'h0; b_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetStall", {31'h0, stall_o}, 32'h0);
    checkOutput("resetHi", hi_o, 32'h0);
    checkOutput("resetLo", lo_o, 32'h0);
    checkOutput("resetResult", result_o, 32'h0);
    rst = 1'b0;

    runOp(OP_MULT, 32'hFFFF_FFFE, 32'd3, stalls);
    checkOutput("multStalls", 32'(stalls), 32'd2);
    checkOutput("multHiBeforeCommit", hi_o, 32'h0);
    idle();
    checkOutput("multHi", hi_o, 32'hFFFF_FFFF);
    checkOutput("multLo", lo_o, 32'hFFFF_FFFA);
    applyStimulus(OP_MFHI, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mfhiResult", result_o, 32'hFFFF_FFFF);
    checkOutput("mfhiStall", {31'h0, stall_o}, 32'h0);
    applyStimulus(OP_MFLO, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mfloResult", result_o, 32'hFFFF_FFFA);

    runOp(OP_MULTU, 32'hFFFF_FFFE, 32'd3, stalls);
    idle();
    checkOutput("multuHi", hi_o, 32'h0000_0002);
    checkOutput("multuLo", lo_o, 32'hFFFF_FFFA);

    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, stalls);
    checkOutput("divStalls", 32'(stalls), 32'd33);
    idle();
    checkOutput("divLo", lo_o, 32'hFFFF_FFFD);
    checkOutput("divHi", hi_o, 32'hFFFF_FFFF);

    runOp(OP_DIVU, 32'd7, 32'd2, stalls);
    idle();
    checkOutput("divuLo", lo_o, 32'd3);
    checkOutput("divuHi", hi_o, 32'd1);

    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
    idle();
    checkOutput("divMinLo", lo_o, 32'h8000_0000);
    checkOutput("divMinHi", hi_o, 32'h0);

    runOp(OP_DIVU, 32'd5, 32'd0, stalls);
    checkOutput("divuZeroStalls", 32'(stalls), 32'd33);
    idle();
    checkOutput("divuZeroLo", lo_o, 32'hFFFF_FFFF);
    checkOutput("divuZeroHi", hi_o, 32'd5);

    runOp(OP_DIV, 32'hFFFF_FFF8, 32'd0, stalls);
    idle();
    checkOutput("divZeroNegLo", lo_o, 32'hFFFF_FFFF);
    checkOutput("divZeroNegHi", hi_o, 32'hFFFF_FFF8);

    // MUL returns its result in DONE and leaves HI/LO alone.
    runOp(OP_MUL, 32'h0001_0000, 32'h0001_0000, stalls);
    checkOutput("mulStalls", 32'(stalls), 32'd2);
    checkOutput("mulResultWrap", result_o, 32'h0);
    idle();
    runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD, stalls);
    checkOutput("mulResultNeg", result_o, 32'hFFFF_FFEB);
    idle();
    checkOutput("mulHiKept", hi_o, 32'hFFFF_FFF8);
    checkOutput("mulLoKept", lo_o, 32'hFFFF_FFFF);

    applyStimulus(OP_MTHI, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    checkOutput("mthiStall", {31'h0, stall_o}, 32'h0);
    idle();
    checkOutput("mthiHi", hi_o, 32'hDEAD_BEEF);
    applyStimulus(OP_MTHI, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
    idle();
    checkOutput("mthiFlushed", hi_o, 32'hDEAD_BEEF);
    applyStimulus(OP_MTLO, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0);
    idle();
    checkOutput("mtloHeld", lo_o, 32'hFFFF_FFFF);
    applyStimulus(OP_MTLO, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0);
    idle();
    checkOutput("mtloLo", lo_o, 32'h0BAD_F00D);

    // Hold for three DONE cycles: no commit until it drops.
    runOp(OP_MULTU, 32'd5, 32'd6, stalls);
    hold_i = 1'b1;
    checkOutput("doneResultZero", result_o, 32'h0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(OP_MULTU, 1'b1, 1'b1, 1'b0, 32'd5, 32'd6);
      checkOutput("holdLoKept", lo_o, 32'h0BAD_F00D);
      checkOutput("holdStall", {31'h0, stall_o}, 32'h0);
    end
    applyStimulus(OP_MULTU, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
    checkOutput("holdReleaseLo", lo_o, 32'h0BAD_F00D);
    idle();
    checkOutput("holdCommitLo", lo_o, 32'd30);
    checkOutput("holdCommitHi", hi_o, 32'h0);

    // Flush on the last divide step: back to IDLE with HI/LO untouched.
    applyStimulus(OP_DIVU, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 31; k++) applyStimulus(OP_DIVU, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    applyStimulus(OP_DIVU, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    checkOutput("flushCycleStall", {31'h0, stall_o}, 32'h1);
    idle();
    checkOutput("flushIdleStall", {31'h0, stall_o}, 32'h0);
    idle();
    checkOutput("flushLoKept", lo_o, 32'd30);
    checkOutput("flushHiKept", hi_o, 32'h0);
    runOp(OP_DIVU, 32'd100, 32'd7, stalls);
    checkOutput("divuAfterFlushStalls", 32'(stalls), 32'd33);
    idle();
    checkOutput("divuAfterFlushLo", lo_o, 32'd14);
    checkOutput("divuAfterFlushHi", hi_o, 32'd2);

    // Asynchronous reset while the divider is at iteration 10.
    applyStimulus(OP_DIV, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 11; k++) applyStimulus(OP_DIV, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    checkOutput("preResetStall", {31'h0, stall_o}, 32'h1);
    en_i = 1'b0;
    rst  = 1'b1;
    #1;
    checkOutput("midResetStall", {31'h0, stall_o}, 32'h0);
    checkOutput("midResetHi", hi_o, 32'h0);
    checkOutput("midResetLo", lo_o, 32'h0);
    idle();
    rst = 1'b0;
    idle();
    checkOutput("postResetStall", {31'h0, stall_o}, 32'h0);
    checkOutput("postResetLo", lo_o, 32'h0);

    runOp(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
    idle();
    checkOutput("recoverHi", hi_o, 32'h0);
    checkOutput("recoverLo", lo_o, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the SimMIPS core's EX stage. It consumes the 4-bit `mdu_op` code and the rs/rt operands produced by instruction decode, and owns the architectural HI/LO registers. It executes MULT/MULTU/MUL in a short multi-cycle sequence and DIV/DIVU with an iterative 32-step restoring divider, holding the pipeline via `stall_o` meanwhile. Its 32-bit result feeds the EX result mux (result_sel = 4).

## Interface
Parameters: none.

- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `mdu_op_i`  in  4  0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO; 10–15 treated as none
- `en_i`  in  1  EX stage holds a valid instruction
- `hold_i`  in  1  pipeline frozen by another cause; EX instruction does not advance this cycle
- `flush_i`  in  1  EX instruction killed (exception); abort, no architectural update
- `a_i`  in  32  rs operand
- `b_i`  in  32  rt operand
- `result_o`  out  32  value for GPR writeback (MFHI/MFLO/MUL)
- `stall_o`  out  1  hold IF/ID/EX; MDU operation in progress
- `hi_o`  out  32  architectural HI (debug/trace)
- `lo_o`  out  32  architectural LO (debug/trace)

## Operation

**FSM states:** IDLE, MULB, DIVB, DONE.

**Internal registers:** `hi`, `lo`, `hi_tmp`, `lo_tmp`, `op_q`, iteration count `cnt[4:0]`, divider remainder/quotient/divisor, sign flags.

**IDLE, `en_i` high:**
- MUL/MULT/MULTU: latch op and operands; go to MULB.
- DIV/DIVU: latch op and operand magnitudes. Magnitudes are unsigned for DIVU and two's-complement absolute values for DIV. Record quotient sign = a[31]^b[31] and remainder sign = a[31] (DIV only). Set cnt=0 and go to DIVB.
- MTHI/MTLO: write `a_i` to HI/LO at the clock edge, only if `!flush_i && !hold_i`.
- MFHI/MFLO: `result_o` = `hi`/`lo` combinationally. No stall.

**MULB:**
- 64-bit product: signed for MULT/MUL, unsigned for MULTU.
- hi_tmp ← product[63:32], lo_tmp ← product[31:0].
- Go to DONE.

**DIVB:**
- One restoring step per cycle, MSB of dividend first; cnt increments.
- When cnt==31, apply the sign fixes and go to DONE: lo_tmp ← quotient, hi_tmp ← remainder.
- Divide by zero: no exception; quotient 0xFFFFFFFF and remainder = a_i. Timing is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.

**DONE:**
- On `!hold_i && !flush_i`: commit hi←hi_tmp, lo←lo_tmp for MULT/MULTU/DIV/DIVU, then go to IDLE.
- MUL never writes HI/LO; `result_o` = lo_tmp in DONE when op_q==MUL.
- While `hold_i` is high, stay in DONE with outputs steady.

**`flush_i` priority:**
- In any non-IDLE state, go to IDLE next edge with no HI/LO write.
- Flush overrides completion and commit in the same cycle.

**`hold_i` in MULB/DIVB:** ignored; computation proceeds. Inputs are ignored outside IDLE.

**`result_o` otherwise:** 0.

## Timing
- Reset: state IDLE, hi=lo=0, tmp and datapath registers 0, `stall_o`=0, `result_o`=0.
- `stall_o` = (IDLE && `en_i` && op∈{DIV,DIVU,MUL,MULT,MULTU} && !`flush_i`) || MULB || DIVB. Combinational.
- Multiply latency:
  - cycle 0 (IDLE) stall=1
  - cycle 1 (MULB) stall=1
  - cycle 2 (DONE) stall=0; commit at end of cycle 2.
- Divide latency:
  - cycle 0 stall=1
  - cycles 1–32 (DIVB) stall=1
  - cycle 33 (DONE) stall=0; commit at end of cycle 33.
- A new MDU instruction is accepted only in IDLE. An MFHI/MFLO directly following reads committed values, so no bypass is needed.
- Reset mid-operation: immediate return to IDLE; HI/LO cleared.

## Test plan
- **Reset:** assert `rst` during DIVB at cnt=10 → next cycle state IDLE, `stall_o`=0, hi_o=lo_o=0.
- **MULT then MFHI/MFLO:** MULT a=0xFFFFFFFE (−2), b=3 → stall cycles 0–1. Then hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. Following MFHI gives result_o=0xFFFFFFFF; MFLO gives 0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **DIV signed:** a=−7, b=2 → `stall_o` high exactly 33 cycles; after commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- **DIV edge cases:** DIV 0x80000000/−1 → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5, timing 33 stall cycles.
- **Flush and hold:**
  - `flush_i` on cycle 32 of DIV → no HI/LO change, IDLE next cycle.
  - `hold_i` held 3 cycles in DONE → state stays DONE, commit only after `hold_i` falls.
- **MUL/MTHI:** MUL 0x10000×0x10000 → result_o=0 in DONE, HI/LO unchanged. MTHI 0xDEADBEEF with `hold_i`=0 → hi_o=0xDEADBEEF next cycle, no stall. The same MTHI with `flush_i`=1 → no write.
